jtpopeye_objdma: RTL

// Parametrised object-table DMA engine, successor of the fixed Popeye sprite DMA.
// On each vertical-blank start it requests the CPU bus and copies OBJS objects of

---
 rtl/jtpopeye_objdma.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/jtpopeye_objdma.sv
// Object-table DMA engine.
// On each vertical-blank start it requests the CPU bus. It then copies OBJS objects of
// BYTES bytes each, starting at a programmable base address, into the object buffer.
// Bytes are assembled into one wide word per object, and each object is written with
// a single strobe.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cen             transfer clock enable, one byte per cen
//   VB              vertical blank (high during blank)
//   base            table start address, sampled on VB rise
//   DD_DMA          CPU RAM read data for the current AD_DMA
//   busak_n         bus acknowledge (active low)
//   busrq_n         bus request (active low)
//   dma_cs          high while the engine owns the address bus
//   AD_DMA          CPU RAM read address
//   obj_we          one-clk object buffer write strobe
//   obj_addr, DO    object index and assembled object (byte 0 in low lane)
//   done            one-clk pulse when the bus is handed back
`timescale 1ns/1ps
module jtpopeye_objdma #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned BYTES     = 4,
  parameter int unsigned OBJS      = 128,
  parameter int unsigned OAW       = 7,
  parameter int unsigned STOP_ZERO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                VB,
  input  logic [AW-1:0]       base,
  input  logic [DW-1:0]       DD_DMA,
  input  logic                busak_n,
  output logic                busrq_n,
  output logic                dma_cs,
  output logic [AW-1:0]       AD_DMA,
  output logic                obj_we,
  output logic [OAW-1:0]      obj_addr,
  output logic [BYTES*DW-1:0] DO,
  output logic                done
);

  localparam int unsigned OW = BYTES * DW;
  localparam int unsigned BW = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t          state_q, state_d;
  logic            vb_q;
  logic [AW-1:0]   base_q, base_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [OAW-1:0]  obj_q, obj_d;
  logic [OW-1:0]   lane_q, lane_d;
  logic            busrq_n_d, dma_cs_d, obj_we_d, done_d;
  logic [AW-1:0]   ad_d;
  logic [OAW-1:0]  obj_addr_d;
  logic [OW-1:0]   do_d;

  logic            vb_rise;
  logic            stop_hit;
  logic            last_byte;
  logic            last_obj;
  logic [OW-1:0]   asm_word;

  assign vb_rise   = VB & ~vb_q;
  assign last_byte = (byte_q == BW'(BYTES - 1));
  assign last_obj  = (obj_q == OAW'(OBJS - 1));

  // A zero in byte 0 of an object ends the list when enabled.
  always_comb begin
    stop_hit = (STOP_ZERO != 0) && (byte_q == '0) && (DD_DMA == '0);
  end

  // Incoming byte merged into its lane of the partially assembled object.
  always_comb begin
    asm_word = lane_q;
    asm_word[32'(byte_q) * DW +: DW] = DD_DMA;
  end

  // State register together with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vb_q     <= 1'b0;
      base_q   <= '0;
      byte_q   <= '0;
      obj_q    <= '0;
      lane_q   <= '0;
      busrq_n  <= 1'b1;
      dma_cs   <= 1'b0;
      AD_DMA   <= '0;
      obj_we   <= 1'b0;
      obj_addr <= '0;
      DO       <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vb_q     <= VB;
      base_q   <= base_d;
      byte_q   <= byte_d;
      obj_q    <= obj_d;
      lane_q   <= lane_d;
      busrq_n  <= busrq_n_d;
      dma_cs   <= dma_cs_d;
      AD_DMA   <= ad_d;
      obj_we   <= obj_we_d;
      obj_addr <= obj_addr_d;
      DO       <= do_d;
      done     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (vb_rise) state_d = REQ;
      REQ: begin
        if (!VB)                   state_d = IDLE;
        else if (cen && !busak_n)  state_d = XFER;
      end
      XFER: if (cen && (!VB || stop_hit || (last_byte && last_obj))) state_d = REL;
      REL:  if (cen && busak_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for datapath and outputs.
  always_comb begin
    base_d     = base_q;
    byte_d     = byte_q;
    obj_d      = obj_q;
    lane_d     = lane_q;
    busrq_n_d  = busrq_n;
    dma_cs_d   = dma_cs;
    ad_d       = AD_DMA;
    obj_we_d   = 1'b0;
    obj_addr_d = obj_addr;
    do_d       = DO;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vb_rise) begin
          base_d    = base;
          busrq_n_d = 1'b0;
        end
      end
      REQ: begin
        if (!VB) begin
          busrq_n_d = 1'b1;
        end else if (cen && !busak_n) begin
          dma_cs_d = 1'b1;
          ad_d     = base_q;
          byte_d   = '0;
          obj_d    = '0;
        end
      end
      XFER: begin
        if (cen) begin
          if (!VB || stop_hit) begin
            // Partial object is dropped; release the bus.
            busrq_n_d = 1'b1;
            dma_cs_d  = 1'b0;
          end else begin
            lane_d = asm_word;
            ad_d   = AD_DMA + AW'(1);
            byte_d = byte_q + BW'(1);
            if (last_byte) begin
              do_d       = asm_word;
              obj_addr_d = obj_q;
              obj_we_d   = 1'b1;
              byte_d     = '0;
              obj_d      = obj_q + OAW'(1);
              if (last_obj) begin
                busrq_n_d = 1'b1;
                dma_cs_d  = 1'b0;
              end
            end
          end
        end
      end
      REL: begin
        if (cen && busak_n) done_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
